// File: rtl/blake2s_compress_ctrl_if.sv
// Block request / chaining-value response bundle for the BLAKE2s sequencer.
// BLAKE2S_CHAIN_EN adds the chain request bit.
interface blake2s_compress_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] h_in;
   logic [511:0] msg;
   logic [63:0]  t;
   logic         last;
`ifdef BLAKE2S_CHAIN_EN
   logic         chain;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [255:0] h_out;

`ifdef BLAKE2S_CHAIN_EN
   modport master (
      output in_valid, h_in, msg, t, last, chain, out_ready,
      input  in_ready, out_valid, h_out
   );
   modport slave (
      input  in_valid, h_in, msg, t, last, chain, out_ready,
      output in_ready, out_valid, h_out
   );
`else
   modport master (
      output in_valid, h_in, msg, t, last, out_ready,
      input  in_ready, out_valid, h_out
   );
   modport slave (
      input  in_valid, h_in, msg, t, last, out_ready,
      output in_ready, out_valid, h_out
   );
`endif
endinterface

// File: rtl/blake2s_compress_ctrl.sv
// BLAKE2s compression sequencer feeding an external half-round G stage.
// BLAKE2S_CHAIN_EN: reuse the last h_out as chaining value on request.
module blake2s_compress_ctrl #(
   parameter int ROUNDS = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   blake2s_compress_ctrl_if.slave    io,
   output logic                      busy,
   output logic                      rnd_mode_sel,
   output logic [511:0]              rnd_v,
   output logic [255:0]              rnd_m,
   input  logic [511:0]              rnd_v_ret
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [4:0] LAST_CNT = 5'(2 * ROUNDS - 1);

   localparam logic [255:0] IV = {
      32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
      32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667
   };

   // Row r of sigma, element j in nibble j.
   function automatic logic [63:0] sigma_row(input logic [3:0] r);
      logic [63:0] row;
      case (r)
         4'd1:    row = 64'h357B20C16DF984AE;
         4'd2:    row = 64'h491763EADF250C8B;
         4'd3:    row = 64'h8F04A562EBCD1397;
         4'd4:    row = 64'hD386CB1EFA427509;
         4'd5:    row = 64'h91EF57D438B0A6C2;
         4'd6:    row = 64'hB8293670A4DEF15C;
         4'd7:    row = 64'hA2684F05931CE7BD;
         4'd8:    row = 64'h5A417D2C803B9EF6;
         4'd9:    row = 64'h0DC3E9BF5167482A;
         default: row = 64'hFEDCBA9876543210;
      endcase
      return row;
   endfunction

   state_e         state_q, state_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [511:0]   v_q, v_d;
   logic [255:0]   h_q, h_d;
   logic [511:0]   m_q, m_d;
   logic [255:0]   h_out_q, h_out_d;
   logic           out_valid_q, out_valid_d;
   logic           in_ready;
   logic [63:0]    row;
   logic [3:0]     idx;
   logic [255:0]   h_init;
   logic [255:0]   tweak;
   logic [511:0]   v_init;

`ifdef BLAKE2S_CHAIN_EN
   assign h_init = io.chain ? h_out_q : io.h_in;
`else
   assign h_init = io.h_in;
`endif

   // Counter and final-block tweak land on v12..v14.
   assign tweak  = {32'h0, {32{io.last}}, io.t[63:32], io.t[31:0], 128'h0};
   assign v_init = {IV ^ tweak, h_init};

   assign io.in_ready  = in_ready;
   assign io.out_valid = out_valid_q;
   assign io.h_out     = h_out_q;
   assign busy         = (state_q != S_IDLE);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      v_d          = v_q;
      h_d          = h_q;
      m_d          = m_q;
      h_out_d      = h_out_q;
      out_valid_d  = out_valid_q;
      in_ready     = 1'b0;
      rnd_v        = v_q;
      rnd_m        = '0;
      rnd_mode_sel = 1'b0;
      idx          = '0;
      row          = sigma_row(cnt_q[4:1]);
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (io.in_valid) begin
               h_d     = h_init;
               m_d     = io.msg;
               v_d     = v_init;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rnd_mode_sel = cnt_q[0];
            for (int k = 0; k < 8; k++) begin
               idx = row[{cnt_q[0], 3'(k), 2'b00} +: 4];
               rnd_m[32*k +: 32] = m_q[{idx, 5'd0} +: 32];
            end
            v_d   = rnd_v_ret;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_CNT) begin
               for (int i = 0; i < 8; i++) begin
                  h_out_d[32*i +: 32] = h_q[32*i +: 32]
                                      ^ rnd_v_ret[32*i +: 32]
                                      ^ rnd_v_ret[32*(i+8) +: 32];
               end
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (io.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         v_q         <= '0;
         h_q         <= '0;
         m_q         <= '0;
         h_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         v_q         <= v_d;
         h_q         <= h_d;
         m_q         <= m_d;
         h_out_q     <= h_out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_blake2s_compress_ctrl.sv
// Directed bench for blake2s_compress_ctrl with a behavioural half-round.
// Known-answer digests for "" and "abc" are hand-entered constants.
`timescale 1ns/1ps
module tb_blake2s_compress_ctrl;

   localparam int ROUNDS = 10;
   localparam int LAT    = 2 * ROUNDS + 1;

   localparam logic [255:0] IVP = {
      32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
      32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6B08E647
   };
   localparam logic [511:0] MSG_ABC = 512'h00636261;

   logic         clk = 1'b0;
   logic         rst;
   logic         busy;
   logic         rnd_mode_sel;
   logic [511:0] rnd_v;
   logic [255:0] rnd_m;
   logic [511:0] rnd_v_ret;
   int           cyc = 0;
   int           n_chk = 0;
   int           n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   blake2s_compress_ctrl_if io ();

   blake2s_compress_ctrl #(.ROUNDS(ROUNDS)) dut (
      .clk          (clk),
      .rst          (rst),
      .io           (io),
      .busy         (busy),
      .rnd_mode_sel (rnd_mode_sel),
      .rnd_v        (rnd_v),
      .rnd_m        (rnd_m),
      .rnd_v_ret    (rnd_v_ret)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [511:0] half_round(
      input logic [511:0] vi, input logic [255:0] mi, input logic sel);
      logic [31:0] w [16];
      logic [511:0] vo;
      int a, b, c, d;
      for (int k = 0; k < 16; k++) w[k] = vi[32*k +: 32];
      for (int i = 0; i < 4; i++) begin
         a = i;
         b = 4 + ((i + int'(sel)) % 4);
         c = 8 + ((i + 2 * int'(sel)) % 4);
         d = 12 + ((i + 3 * int'(sel)) % 4);
         w[a] = w[a] + w[b] + mi[64*i +: 32];
         w[d] = ror(w[d] ^ w[a], 16);
         w[c] = w[c] + w[d];
         w[b] = ror(w[b] ^ w[c], 12);
         w[a] = w[a] + w[b] + mi[64*i+32 +: 32];
         w[d] = ror(w[d] ^ w[a], 8);
         w[c] = w[c] + w[d];
         w[b] = ror(w[b] ^ w[c], 7);
      end
      for (int k = 0; k < 16; k++) vo[32*k +: 32] = w[k];
      return vo;
   endfunction

   always_comb rnd_v_ret = half_round(rnd_v, rnd_m, rnd_mode_sel);

   task automatic chk(input string tag, input logic [511:0] act,
                      input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic send(input logic [255:0] h, input logic [511:0] m,
                       input logic [63:0] tt, input logic l,
                       output int acc);
      int n;
      n = 0;
      @(negedge clk);
      io.h_in     = h;
      io.msg      = m;
      io.t        = tt;
      io.last     = l;
      io.in_valid = 1'b1;
      while (!io.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", io.in_ready, 1'b1);
      acc = cyc;
      @(posedge clk);
      #1 io.in_valid = 1'b0;
   endtask

   task automatic wait_out(output int oc);
      int n;
      n = 0;
      @(negedge clk);
      while (!io.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("out_valid_seen", io.out_valid, 1'b1);
      oc = cyc;
   endtask

   task automatic drain();
      io.out_ready = 1'b1;
      @(posedge clk);
      #1 io.out_ready = 1'b0;
   endtask

   initial begin
      int acc, oc, hs;
      logic [255:0] held;
`ifdef BLAKE2S_CHAIN_EN
      logic [255:0] h1, h2c;
`endif
      rst          = 1'b1;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      io.h_in      = '0;
      io.msg       = '0;
      io.t         = '0;
      io.last      = 1'b0;
`ifdef BLAKE2S_CHAIN_EN
      io.chain     = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", io.in_ready, 1'b1);
      chk("rst_out_valid", io.out_valid, 1'b0);
      chk("rst_h_out", io.h_out, 256'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rnd_v", rnd_v, 512'h0);
      chk("rst_rnd_m", rnd_m, 256'h0);

      // Empty message, then backpressure on its result.
      send(IVP, 512'h0, 64'h0, 1'b1, acc);
      @(negedge clk);
      chk("e_v0", rnd_v[31:0], 32'h6B08E647);
      chk("e_v12", rnd_v[415:384], 32'h510E527F);
      chk("e_v14", rnd_v[479:448], 32'hE07C2654);
      wait_out(oc);
      chk("e_latency", oc - acc, LAT);
      chk("e_w0", io.h_out[31:0], 32'h307A2169);
      chk("e_w7", io.h_out[255:224], 32'hF9EED01E);
      held = io.h_out;
      io.msg = {16{32'hDEADBEEF}};
      for (int i = 0; i < 10; i++) begin
         io.in_valid = i[0];
         @(negedge clk);
         chk("bp_hold", io.h_out, held);
         chk("bp_in_ready", io.in_ready, 1'b0);
         chk("bp_out_valid", io.out_valid, 1'b1);
      end
      io.in_valid = 1'b0;
      drain();
      @(negedge clk);
      chk("bp_rel_in_ready", io.in_ready, 1'b1);
      chk("bp_rel_out_valid", io.out_valid, 1'b0);

      // Message schedule spot checks, m[k] = 0x100 + k.
      begin
         logic [511:0] mi;
         for (int k = 0; k < 16; k++) mi[32*k +: 32] = 32'h100 + k;
         send(IVP, mi, 64'h0000_0002_0000_0040, 1'b0, acc);
      end
      @(negedge clk);
      chk("s0_v12", rnd_v[415:384], 32'h510E523F);
      chk("s0_v13", rnd_v[447:416], 32'h9B05688E);
      chk("s0_v14", rnd_v[479:448], 32'h1F83D9AB);
      chk("s0_sel", rnd_mode_sel, 1'b0);
      chk("s0_m", {rnd_m[255:224], rnd_m[31:0]}, {32'h107, 32'h100});
      chk("s0_busy", busy, 1'b1);
      @(negedge clk);
      chk("s1_sel", rnd_mode_sel, 1'b1);
      chk("s1_m", {rnd_m[255:224], rnd_m[31:0]}, {32'h10F, 32'h108});
      @(negedge clk);
      chk("s2_m", {rnd_m[255:224], rnd_m[31:0]}, {32'h106, 32'h10E});
      @(negedge clk);
      chk("s3_m", {rnd_m[255:224], rnd_m[31:0]}, {32'h103, 32'h101});
      repeat (16) @(negedge clk);
      chk("s19_m", {rnd_m[255:224], rnd_m[31:0]}, {32'h100, 32'h10F});
      chk("s19_ov", io.out_valid, 1'b0);
      @(negedge clk);
      chk("s_done_ov", io.out_valid, 1'b1);
      chk("s_done_m", rnd_m, 256'h0);
      drain();

      // Reset while counter = 7.
      send(IVP, MSG_ABC, 64'd3, 1'b1, acc);
      repeat (8) @(negedge clk);
      chk("r7_sel", rnd_mode_sel, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("r_out_valid", io.out_valid, 1'b0);
      chk("r_in_ready", io.in_ready, 1'b1);
      rst = 1'b0;
      send(IVP, MSG_ABC, 64'd3, 1'b1, acc);
      wait_out(oc);
      chk("a_latency", oc - acc, LAT);
      chk("a_w0", io.h_out[31:0], 32'h8C5E8C50);
      chk("a_w7", io.h_out[255:224], 32'h82596786);
      drain();

      // Back-to-back with in_valid held high.
      @(negedge clk);
      io.h_in = IVP; io.msg = '0; io.t = '0; io.last = 1'b1;
      io.in_valid = 1'b1;
      @(posedge clk);
      #1 io.msg = MSG_ABC;
      io.t = 64'd3;
      wait_out(oc);
      chk("b1_w0", io.h_out[31:0], 32'h307A2169);
      drain();
      hs = cyc;
      @(negedge clk);
      chk("b2_in_ready", io.in_ready, 1'b1);
      acc = cyc;
      chk("b2_gap", acc - hs, 0);
      @(posedge clk);
      #1 io.in_valid = 1'b0;
      wait_out(oc);
      chk("b2_latency", oc - acc, LAT);
      chk("b2_w0", io.h_out[31:0], 32'h8C5E8C50);
      chk("b2_w7", io.h_out[255:224], 32'h82596786);
      drain();

`ifdef BLAKE2S_CHAIN_EN
      // "a"*65: internal chaining must equal explicit feedback.
      send(IVP, {16{32'h61616161}}, 64'd64, 1'b0, acc);
      wait_out(oc);
      h1 = io.h_out;
      drain();
      io.chain = 1'b1;
      send({8{32'hA5A5A5A5}}, 512'h61, 64'd65, 1'b1, acc);
      io.chain = 1'b0;
      wait_out(oc);
      h2c = io.h_out;
      drain();
      send(h1, 512'h61, 64'd65, 1'b1, acc);
      wait_out(oc);
      chk("chain_eq", h2c, io.h_out);
      drain();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
